dvsd_cmp_iter: RTL and testbench

Parametrised, multi-cycle magnitude comparator, next generation of the 4-bit `dvsd_cmp`.

- Compares two WIDTH-bit operands CHUNK bits per clock, MSB chunk first, with optional early exit on the first differing chunk.
- Supports unsigned or two's-complement signed comparison, selected per transaction.
- Uses a start/busy/done handshake and holds registered less/equal/greater flags until the next completion.
- Sits between operand-producing datapath logic and control logic that needs ordered compare results at widths where a single-cycle compare is too slow.

---
 rtl/dvsd_cmp_iter.sv | 149 ++++++++++++++
 tb/tb_dvsd_cmp_iter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvsd_cmp_iter.sv
// dvsd_cmp_iter: multi-cycle magnitude comparator.
// Compares two WIDTH-bit operands CHUNK bits per clock, most significant chunk
// first. Signed compares reuse the unsigned datapath by flipping the MSB of
// both operands when they are captured (offset binary).
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         request a compare (ignored while busy)
//   signed_mode   1 = two's-complement compare, sampled with start
//   A_in, B_in    operands, sampled with start
//   busy          compare in progress
//   done          one-cycle pulse when the flags below are updated
//   less_than     A < B, held until the next completion
//   equal_to      A == B, held until the next completion
//   greater_than  A > B, held until the next completion
//   chunks_used   chunks evaluated by the last compare
//
// state  | meaning
// -------+---------------------------------------------------
// S_IDLE | waiting for start; flags hold the last result
// S_CMP  | evaluating chunk idx_q, one chunk per clock

module dvsd_cmp_iter #(
    parameter int WIDTH      = 16,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1,
    localparam int NCHUNK    = WIDTH / CHUNK,
    localparam int CNTW      = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             busy,
    output logic             done,
    output logic             less_than,
    output logic             equal_to,
    output logic             greater_than,
    output logic [CNTW-1:0]  chunks_used
);

    localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {S_IDLE, S_CMP} state_t;

    state_t           state_q, state_nx;
    logic [WIDTH-1:0] a_q, b_q, a_nx, b_nx;
    logic [IDXW-1:0]  idx_q, idx_nx;
    logic [CNTW-1:0]  cnt_q, cnt_nx;
    logic             pend_lt_q, pend_gt_q, pend_lt_nx, pend_gt_nx;
    logic             lt_nx, eq_nx, gt_nx, done_nx;
    logic [CNTW-1:0]  cu_nx;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic             chunk_lt, chunk_gt, diff_seen, finish;

    assign a_chunk   = a_q[int'(idx_q)*CHUNK +: CHUNK];
    assign b_chunk   = b_q[int'(idx_q)*CHUNK +: CHUNK];
    assign chunk_lt  = a_chunk < b_chunk;
    assign chunk_gt  = a_chunk > b_chunk;
    assign diff_seen = pend_lt_q | pend_gt_q;
    assign busy      = (state_q == S_CMP);

    always_comb begin
        state_nx   = state_q;
        a_nx       = a_q;
        b_nx       = b_q;
        idx_nx     = idx_q;
        cnt_nx     = cnt_q;
        pend_lt_nx = pend_lt_q;
        pend_gt_nx = pend_gt_q;
        lt_nx      = less_than;
        eq_nx      = equal_to;
        gt_nx      = greater_than;
        cu_nx      = chunks_used;
        done_nx    = 1'b0;
        finish     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_nx       = A_in ^ (signed_mode ? MSB_MASK : '0);
                    b_nx       = B_in ^ (signed_mode ? MSB_MASK : '0);
                    idx_nx     = IDXW'(NCHUNK - 1);
                    cnt_nx     = '0;
                    pend_lt_nx = 1'b0;
                    pend_gt_nx = 1'b0;
                    state_nx   = S_CMP;
                end
            end
            S_CMP: begin
                cnt_nx = cnt_q + CNTW'(1);
                // The first differing chunk decides; less significant chunks
                // are still counted but cannot change the pending result.
                if (!diff_seen) begin
                    pend_lt_nx = chunk_lt;
                    pend_gt_nx = chunk_gt;
                end
                finish = (idx_q == '0) ||
                         ((EARLY_EXIT != 0) && (diff_seen || chunk_lt || chunk_gt));
                if (finish) begin
                    lt_nx    = pend_lt_nx;
                    gt_nx    = pend_gt_nx;
                    eq_nx    = ~(pend_lt_nx | pend_gt_nx);
                    cu_nx    = cnt_nx;
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    idx_nx = idx_q - IDXW'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            pend_lt_q    <= 1'b0;
            pend_gt_q    <= 1'b0;
            less_than    <= 1'b0;
            equal_to     <= 1'b0;
            greater_than <= 1'b0;
            chunks_used  <= '0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_nx;
            a_q          <= a_nx;
            b_q          <= b_nx;
            idx_q        <= idx_nx;
            cnt_q        <= cnt_nx;
            pend_lt_q    <= pend_lt_nx;
            pend_gt_q    <= pend_gt_nx;
            less_than    <= lt_nx;
            equal_to     <= eq_nx;
            greater_than <= gt_nx;
            chunks_used  <= cu_nx;
            done         <= done_nx;
        end
    end

endmodule

// File: tb/tb_dvsd_cmp_iter.sv
module tb_dvsd_cmp_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sm = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;

    logic busy_v[3], done_v[3], lt_v[3], eq_v[3], gt_v[3];
    logic [2:0] cu0, cu1;
    logic [0:0] cu2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // u0: default early-exit, u1: full scan always, u2: legacy 4-bit
    dvsd_cmp_iter #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
        .A_in(a_in), .B_in(b_in), .busy(busy_v[0]), .done(done_v[0]),
        .less_than(lt_v[0]), .equal_to(eq_v[0]), .greater_than(gt_v[0]),
        .chunks_used(cu0));

    dvsd_cmp_iter #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
        .A_in(a_in), .B_in(b_in), .busy(busy_v[1]), .done(done_v[1]),
        .less_than(lt_v[1]), .equal_to(eq_v[1]), .greater_than(gt_v[1]),
        .chunks_used(cu1));

    dvsd_cmp_iter #(.WIDTH(4), .CHUNK(4), .EARLY_EXIT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
        .A_in(a_in[3:0]), .B_in(b_in[3:0]), .busy(busy_v[2]), .done(done_v[2]),
        .less_than(lt_v[2]), .equal_to(eq_v[2]), .greater_than(gt_v[2]),
        .chunks_used(cu2));

    int mw[3] = '{16, 16, 4};
    bit me[3] = '{1'b1, 1'b0, 1'b1};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // res: -1 A<B, 0 equal, 1 A>B; k: chunks examined
    function automatic void ref_cmp(input logic [15:0] a, input logic [15:0] b,
                                    input bit s, input int w, input int ch,
                                    input bit early, output int res, output int k);
        int ua, ub, va, vb, n;
        ua = int'(a) & ((1 << w) - 1);
        ub = int'(b) & ((1 << w) - 1);
        va = ua;
        vb = ub;
        if (s && va >= (1 << (w - 1))) va -= (1 << w);
        if (s && vb >= (1 << (w - 1))) vb -= (1 << w);
        res = (va < vb) ? -1 : ((va == vb) ? 0 : 1);
        n = w / ch;
        k = n;
        if (early) begin
            for (int j = 0; j < n; j++) begin
                if (((ua >> (w - ch*(j+1))) & ((1 << ch) - 1)) !=
                    ((ub >> (w - ch*(j+1))) & ((1 << ch) - 1))) begin
                    k = j + 1;
                    break;
                end
            end
        end
    endfunction

    // Transaction-level model: a compare occupies k cycles, then a done pulse.
    bit m_busy[3], m_done[3], m_lt[3], m_eq[3], m_gt[3];
    int m_cu[3], m_rem[3], p_res[3], p_k[3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_busy[i] = 0; m_done[i] = 0; m_lt[i] = 0; m_eq[i] = 0;
                m_gt[i] = 0; m_cu[i] = 0; m_rem[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_done[i] = 0;
                if (m_busy[i]) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_busy[i] = 0;
                        m_done[i] = 1;
                        m_lt[i] = (p_res[i] < 0);
                        m_eq[i] = (p_res[i] == 0);
                        m_gt[i] = (p_res[i] > 0);
                        m_cu[i] = p_k[i];
                    end
                end else if (start) begin
                    ref_cmp(a_in, b_in, sm, mw[i], 4, me[i], p_res[i], p_k[i]);
                    m_rem[i] = p_k[i];
                    m_busy[i] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int cu[3];
        cu[0] = int'(cu0);
        cu[1] = int'(cu1);
        cu[2] = int'(cu2);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("busy[%0d]", i), busy_v[i], m_busy[i]);
            check($sformatf("done[%0d]", i), done_v[i], m_done[i]);
            check($sformatf("lt[%0d]", i), lt_v[i], m_lt[i]);
            check($sformatf("eq[%0d]", i), eq_v[i], m_eq[i]);
            check($sformatf("gt[%0d]", i), gt_v[i], m_gt[i]);
            check($sformatf("cu[%0d]", i), cu[i], m_cu[i]);
        end
    end

    task automatic idle_wait();
        int t = 0;
        while ((busy_v[0] | busy_v[1] | busy_v[2]) && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", (t < 40), 1);
        @(negedge clk);
    endtask

    // Called at a negedge with all instances idle; nb = busy cycles of u0.
    task automatic txn(input logic [15:0] a, input logic [15:0] b, input bit s, output int nb);
        a_in = a; b_in = b; sm = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy_v[0] && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        idle_wait();
    endtask

    initial begin
        int nb, r, k, t;

        ref_cmp(16'h8000, 16'h7FFF, 1'b1, 16, 4, 1'b1, r, k);
        check("model_signed_res", r, -1);
        check("model_signed_k", k, 1);
        ref_cmp(16'h1235, 16'h1234, 1'b0, 16, 4, 1'b1, r, k);
        check("model_last_res", r, 1);
        check("model_last_k", k, 4);
        ref_cmp(16'h0008, 16'h0009, 1'b0, 4, 4, 1'b1, r, k);
        check("model_legacy_res", r, -1);

        repeat (3) @(negedge clk);
        check("rst_busy", busy_v[0], 0);
        check("rst_eq", eq_v[0], 0);
        check("rst_cu", cu0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        txn(16'h8000, 16'h7FFF, 1'b0, nb);
        check("uns_gt", gt_v[0], 1);
        check("uns_cu", cu0, 1);
        check("uns_lat", nb, 1);
        check("noexit_gt", gt_v[1], 1);
        check("noexit_cu", cu1, 4);
        check("legacy_lt", lt_v[2], 1);

        txn(16'h8000, 16'h7FFF, 1'b1, nb);
        check("sgn_lt", lt_v[0], 1);
        check("sgn_cu", cu0, 1);

        txn(16'h1234, 16'h1234, 1'b0, nb);
        check("full_eq", eq_v[0], 1);
        check("full_cu", cu0, 4);
        check("full_busy", nb, 4);

        txn(16'h1235, 16'h1234, 1'b0, nb);
        check("last_gt", gt_v[0], 1);
        check("last_cu", cu0, 4);

        txn(16'hFFFF, 16'h0000, 1'b1, nb);
        check("neg1_lt", lt_v[0], 1);
        check("neg1_legacy_lt", lt_v[2], 1);

        txn(16'h0008, 16'h0009, 1'b0, nb);
        check("leg_8_9", lt_v[2], 1);
        check("leg_cu", cu2, 1);
        txn(16'h000F, 16'h000F, 1'b0, nb);
        check("leg_f_f", eq_v[2], 1);
        txn(16'h000C, 16'h0003, 1'b0, nb);
        check("leg_c_3", gt_v[2], 1);

        // start during busy is ignored, start in the done cycle is accepted
        a_in = 16'h1234; b_in = 16'h1234; sm = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a_in = 16'h0000; b_in = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!done_v[0] && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("hs_done_seen", (t < 40), 1);
        check("hs_inflight_eq", eq_v[0], 1);
        check("hs_inflight_cu", cu0, 4);
        a_in = 16'h0001; b_in = 16'h0002; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy_v[0] && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        check("b2b_busy", nb, 4);
        check("b2b_lt", lt_v[0], 1);
        check("b2b_cu", cu0, 4);
        idle_wait();

        // reset during a 4-chunk compare
        a_in = 16'h1234; b_in = 16'h1235; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy_v[0], 0);
        check("abort_done", done_v[0], 0);
        check("abort_lt", lt_v[0], 0);
        check("abort_cu", cu0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(16'hAAAA, 16'hAAAA, 1'b0, nb);
        check("post_rst_eq", eq_v[0], 1);

        for (int c = 0; c < 1500; c++) begin
            logic [15:0] ra;
            ra = 16'($urandom);
            a_in = ra;
            case ($urandom % 4)
                0: b_in = 16'($urandom);
                1: b_in = ra;
                2: b_in = ra ^ (16'd1 << ($urandom % 16));
                default: b_in = ra ^ 16'($urandom % 16);
            endcase
            sm = 1'($urandom % 2);
            start = ($urandom % 3 == 0);
            @(negedge clk);
        end
        start = 1'b0;
        idle_wait();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
